imm_ext_pipe: RTL
=================

# imm_ext_pipe

Fetch/decode boundary stage placed directly downstream of the immediate-select decoder. It accepts one instruction per cycle with its 3-bit immediate-select code and incremented PC, and forms the 16-bit extended immediate and the PC-relative target. It holds up to two entries in a skid buffer so its input ready is a flop output, and presents the results to the decode/register-read stage over a valid/ready handshake. Flush support discards wrong-path instructions after a taken branch or jump.

## Interface
- DATA_W, 16, instruction/PC/immediate width
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- flush  in  1  synchronous discard of all held and incoming entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept; registered
- in_instr  in  16  fetched instruction
- in_pc_inc  in  16  PC+2 of that instruction
- in_sel  in  3  immediate-select code from the select decoder
- out_valid  out  1  head entry present
- out_ready  in  1  downstream consumes head
- out_instr  out  16  head instruction
- out_pc_inc  out  16  head PC+2
- out_imm  out  16  extended immediate
- out_tgt  out  16  out_pc_inc + out_imm, modulo 2^16
- out_sel_err  out  1  head carried an undefined select code

## Operation
- Select codes: 000 zero-extend instr[4:0]; 001 zero-extend instr[7:0]; 010 sign-extend instr[4:0]; 100 sign-extend instr[7:0]; 110 sign-extend instr[10:0]. Codes 011, 101, 111 undefined: imm = 0, sel_err = 1, entry still flows.
- Extension and target add occur at capture; each entry stores instr, pc_inc, imm, tgt, sel_err.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Occupancy FSM: EMPTY, ONE, FULL.
  - EMPTY: accept -> ONE.
  - ONE: accept & !drain -> FULL; drain & !accept -> EMPTY; both -> ONE, new entry becomes head.
  - FULL: no accept possible; drain -> ONE, second entry becomes head.
- in_ready = 1 in EMPTY and ONE, 0 in FULL (registered, updated with the state).
- Order strictly FIFO; no entry lost or duplicated.
- flush: next state EMPTY and in_ready = 1 regardless of in_valid/out_ready. A same-cycle accept is discarded. A same-cycle drain is counted as taken by downstream.
- Outputs hold stable while out_valid & !out_ready.
- Target add wraps modulo 2^16; no overflow flag.

## Timing
- Reset (asynchronous, rst_n low): state EMPTY, out_valid 0, in_ready 1, all data outputs and out_sel_err 0. Reset mid-operation drops all entries immediately.
- Latency: entry accepted at edge N appears with out_valid = 1 after edge N, i.e. visible in cycle N+1. There is no combinational path from in_* to out_*.
- There is no combinational path from out_ready to in_ready. in_ready falls one cycle after the second accept into a non-draining stage.
- Throughput: one entry per cycle sustained when out_ready stays high.
- flush asserted at edge N: out_valid = 0 and in_ready = 1 in cycle N+1.

## Structure
- Shared package: DATA_W, the select-code constants (SEL_ZX5, SEL_ZX8, SEL_SX5, SEL_SX8, SEL_SX11), and the entry record type (instr, pc_inc, imm, tgt, sel_err).
- The immediate decoder and the same select-code constants come from the package.
- Sub-module imm_ext is combinational: instr and sel in, imm and sel_err out. It is instantiated once at the input.
- The top level holds two entry registers, the occupancy FSM and the handshake logic.

## Test plan
- Extension per code, with in_instr = 16'h07F5 and pc_inc = 16'h0100, one entry each:
  - sel 000 -> imm 0015, tgt 0115.
  - sel 001 -> imm 00F5, tgt 01F5.
  - sel 010 -> imm FFF5, tgt 00F5.
  - sel 100 -> imm FFF5, tgt 00F5.
  - sel 110 -> imm FFF5, tgt 00F5.
  - sel 011 -> imm 0000, tgt 0100, sel_err 1.
- Backpressure: out_ready = 0 while three consecutive in_valid entries A, B, C are presented -> A and B accepted, in_ready = 0 in cycle 3 and C is held. Then out_ready = 1 -> outputs A, B, C in order, with no gaps after in_ready recovers.
- Streaming: in_valid and out_ready held high for 8 cycles -> 8 entries out, each 1 cycle after its accept, state never FULL.
- Flush in FULL with in_valid = 1 and out_ready = 0 -> next cycle out_valid = 0, in_ready = 1, and the incoming entry never appears.
- Wrap: pc_inc = FFFE, sel 100, instr[7:0] = 04 -> tgt 0002.
- Asynchronous reset asserted mid-stream between clock edges -> out_valid drops to 0 immediately and in_ready = 1. After release, the first new entry emerges correctly.

Source files
------------

// File: rtl/imm_ext_pipe_pkg.sv
// imm_ext_pipe_pkg
// Shared definitions for the fetch/decode immediate-extension stage:
//   - data width and immediate-field width
//   - immediate-select codes driven by the upstream select decoder
//   - the stored entry record and the occupancy state encoding
//   - imm_decode(): the immediate decoder, used by the imm_ext sub-module
package imm_ext_pipe_pkg;

  localparam int DATA_W   = 16;
  localparam int SEL_W    = 3;
  // Every immediate field lives in instr[10:0].
  localparam int IMM_SRC_W = 11;

  localparam logic [SEL_W-1:0] SEL_ZX5  = 3'b000;
  localparam logic [SEL_W-1:0] SEL_ZX8  = 3'b001;
  localparam logic [SEL_W-1:0] SEL_SX5  = 3'b010;
  localparam logic [SEL_W-1:0] SEL_SX8  = 3'b100;
  localparam logic [SEL_W-1:0] SEL_SX11 = 3'b110;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc_inc;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] tgt;
    logic              sel_err;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

  // Returns {sel_err, imm}. Undefined codes give imm = 0 with sel_err set;
  // the entry still flows so decode can raise the illegal-instruction trap.
  function automatic logic [DATA_W:0] imm_decode(input logic [IMM_SRC_W-1:0] src,
                                                 input logic [SEL_W-1:0]     sel);
    logic [DATA_W-1:0] imm;
    logic              err;
    imm = '0;
    err = 1'b0;
    case (sel)
      SEL_ZX5:  imm = {11'b0, src[4:0]};
      SEL_ZX8:  imm = {8'b0, src[7:0]};
      SEL_SX5:  imm = {{11{src[4]}}, src[4:0]};
      SEL_SX8:  imm = {{8{src[7]}}, src[7:0]};
      SEL_SX11: imm = {{5{src[10]}}, src[10:0]};
      default: begin
        imm = '0;
        err = 1'b1;
      end
    endcase
    return {err, imm};
  endfunction

endpackage

// File: rtl/imm_ext_pipe_if.sv
// imm_ext_pipe_if
// Upstream (in_*) and downstream (out_*) handshake bundle of imm_ext_pipe.
//   master: the environment side (fetch feeding in_*, decode consuming out_*)
//   slave : the stage itself
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The sender keeps valid and payload stable until that edge;
// ready may toggle freely and never depends combinationally on valid here.
interface imm_ext_pipe_if;
  import imm_ext_pipe_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic [DATA_W-1:0] in_pc_inc;
  logic [SEL_W-1:0]  in_sel;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [DATA_W-1:0] out_pc_inc;
  logic [DATA_W-1:0] out_imm;
  logic [DATA_W-1:0] out_tgt;
  logic              out_sel_err;

  modport master (
    output in_valid, in_instr, in_pc_inc, in_sel, out_ready,
    input  in_ready, out_valid, out_instr, out_pc_inc, out_imm, out_tgt, out_sel_err
  );

  modport slave (
    input  in_valid, in_instr, in_pc_inc, in_sel, out_ready,
    output in_ready, out_valid, out_instr, out_pc_inc, out_imm, out_tgt, out_sel_err
  );

endinterface

// File: rtl/imm_ext_pipe_imm_ext.sv
// imm_ext
// Combinational immediate extender placed at the stage input.
//   instr   in  immediate source field, instr[10:0] of the fetched word
//   sel     in  immediate-select code
//   imm     out extended 16-bit immediate
//   sel_err out sel is one of the undefined codes
module imm_ext
  import imm_ext_pipe_pkg::*;
(
  input  logic [IMM_SRC_W-1:0] instr,
  input  logic [SEL_W-1:0]     sel,
  output logic [DATA_W-1:0]    imm,
  output logic                 sel_err
);

  always_comb begin
    {sel_err, imm} = imm_decode(instr, sel);
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe
// Fetch/decode boundary stage: extends the immediate and forms the
// PC-relative target at capture, then buffers up to two entries in a skid
// buffer so in_ready comes straight from a flop.
//   clk       in  rising-edge clock
//   rst_n     in  asynchronous active-low reset
//   flush     in  synchronous discard of held and incoming entries
//   bus       slave side of imm_ext_pipe_if (in_* accept, out_* present)
//   dbg_state out occupancy FSM state
module imm_ext_pipe
  import imm_ext_pipe_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  imm_ext_pipe_if.slave bus,
  output occ_state_e    dbg_state
);

  occ_state_e state_q, state_d;
  entry_t     head_q, tail_q;
  entry_t     new_entry;
  logic       in_ready_q;

  logic [DATA_W-1:0] new_imm;
  logic              new_err;

  logic accept, drain;
  logic load_head_new, load_head_tail, load_tail;

  imm_ext u_imm_ext (
    .instr   (bus.in_instr[IMM_SRC_W-1:0]),
    .sel     (bus.in_sel),
    .imm     (new_imm),
    .sel_err (new_err)
  );

  always_comb begin
    new_entry         = '0;
    new_entry.instr   = bus.in_instr;
    new_entry.pc_inc  = bus.in_pc_inc;
    new_entry.imm     = new_imm;
    new_entry.tgt     = bus.in_pc_inc + new_imm;  // wraps modulo 2^16
    new_entry.sel_err = new_err;
  end

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = (state_q != ST_EMPTY) & bus.out_ready;

  // Next state and register-load selects. head_q is always the oldest entry.
  always_comb begin
    state_d        = state_q;
    load_head_new  = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d       = ST_ONE;
          load_head_new = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !drain) begin
          state_d   = ST_FULL;
          load_tail = 1'b1;
        end else if (drain && !accept) begin
          state_d = ST_EMPTY;
        end else if (drain && accept) begin
          load_head_new = 1'b1;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so accept cannot occur.
        if (drain) begin
          state_d        = ST_ONE;
          load_head_tail = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // A same-cycle drain is still consumed downstream; the incoming entry
    // is dropped.
    if (flush) begin
      state_d        = ST_EMPTY;
      load_head_new  = 1'b0;
      load_head_tail = 1'b0;
      load_tail      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      // Registered ready: derived from the next state, never from out_ready
      // within the same cycle.
      in_ready_q <= (state_d != ST_FULL);
      if (load_head_new) begin
        head_q <= new_entry;
      end else if (load_head_tail) begin
        head_q <= tail_q;
      end
      if (load_tail) begin
        tail_q <= new_entry;
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = (state_q != ST_EMPTY);
  assign bus.out_instr   = head_q.instr;
  assign bus.out_pc_inc  = head_q.pc_inc;
  assign bus.out_imm     = head_q.imm;
  assign bus.out_tgt     = head_q.tgt;
  assign bus.out_sel_err = head_q.sel_err;
  assign dbg_state       = state_q;

endmodule
